// File: rtl/shift_frame_rx.sv
// shift_frame_rx: serial frame receiver (start, WIDTH data bits, even parity, stop) with a one-word output buffer
module shift_frame_rx #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             msb_first,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic             busy,
   output logic             par_err,
   output logic             frame_err,
   output logic             ovr_err
);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam int CW = $clog2(WIDTH);
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_shift;
   logic             r_order;
   logic             r_pbit;
   logic [WIDTH-1:0] r_q;
   logic             r_qv;
   logic             r_pe;
   logic             r_fe;
   logic             r_oe;
   logic [WIDTH-1:0] w_shifted;
   logic             w_pok;
   logic             w_good;
   logic             w_load;
   assign w_shifted = r_order ? {r_shift[WIDTH-2:0], sin} : {sin, r_shift[WIDTH-1:1]};
   assign w_pok     = ~(^r_shift ^ r_pbit);
   assign w_good    = sin && w_pok;
   assign w_load    = w_good && (!r_qv || q_ready);
   // Frame FSM, assembly register, output buffer and error pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_order <= 1'b0;
         r_pbit  <= 1'b0;
         r_q     <= '0;
         r_qv    <= 1'b0;
         r_pe    <= 1'b0;
         r_fe    <= 1'b0;
         r_oe    <= 1'b0;
      end else begin
         r_pe <= 1'b0;
         r_fe <= 1'b0;
         r_oe <= 1'b0;
         if (r_qv && q_ready) r_qv <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!sin) begin
                  r_state <= DATA;
                  r_cnt   <= '0;
                  r_order <= msb_first;
               end
            end
            DATA: begin
               r_shift <= w_shifted;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) r_state <= PARITY;
            end
            PARITY: begin
               r_pbit  <= sin;
               r_state <= STOP;
            end
            STOP: begin
               r_state <= IDLE;
               r_fe    <= !sin;
               r_pe    <= sin && !w_pok;
               r_oe    <= w_good && r_qv && !q_ready;
               if (w_load) begin
                  r_q  <= r_shift;
                  r_qv <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign q         = r_q;
   assign q_valid   = r_qv;
   assign busy      = (r_state != IDLE);
   assign par_err   = r_pe;
   assign frame_err = r_fe;
   assign ovr_err   = r_oe;
endmodule

// File: tb/tb_shift_frame_rx.sv
// tb_shift_frame_rx: table vectors, hand sequences and random frames against a frame-level model
module tb_shift_frame_rx;
   logic       clk = 1'b0;
   logic       reset;
   logic       sin;
   logic       msb_first;
   logic [3:0] q;
   logic       q_valid;
   logic       q_ready;
   logic       busy;
   logic       par_err;
   logic       frame_err;
   logic       ovr_err;
   int         total = 0;
   int         bad = 0;
   logic [3:0] m_q;
   logic       m_qv;

   shift_frame_rx #(.WIDTH(4)) dut (
      .clk(clk), .reset(reset), .sin(sin), .msb_first(msb_first),
      .q(q), .q_valid(q_valid), .q_ready(q_ready), .busy(busy),
      .par_err(par_err), .frame_err(frame_err), .ovr_err(ovr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         o;
      logic [3:0] d;
      bit         p;
      bit         s;
      bit         r;
      logic [3:0] eq;
      bit         eqv;
      bit         epe;
      bit         efe;
      bit         eov;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   task automatic send_frame(input bit o, input logic [3:0] d, input bit p, input bit s,
                             input bit r, input bit h, input bit scr);
      msb_first = o;
      q_ready = h ? r : 1'b0;
      sin = 1'b0;
      tick();
      chk("busy_in_frame", 16'(busy), 16'd1);
      if (h && r) chk("qv_drop", 16'(q_valid), 16'd0);
      if (scr) msb_first = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
         sin = o ? d[3-i] : d[i];
         tick();
      end
      sin = p;
      tick();
      sin = s;
      q_ready = r;
      tick();
      sin = 1'b1;
      q_ready = 1'b0;
   endtask

   task automatic gap(input int n);
      sin = 1'b1;
      q_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (i == 0) begin
            chk("pulse_end", 16'({par_err, frame_err, ovr_err}), 16'd0);
            chk("idle_busy", 16'(busy), 16'd0);
         end
      end
   endtask

   task automatic chk_out(input string n, input logic [3:0] eq, input bit eqv,
                          input bit epe, input bit efe, input bit eov);
      chk({n, "_q"}, 16'(q), 16'(eq));
      chk({n, "_qv"}, 16'(q_valid), 16'(eqv));
      chk({n, "_err"}, 16'({par_err, frame_err, ovr_err}), 16'({epe, efe, eov}));
   endtask

   initial begin
      vec_t vecs[10];
      vecs[0] = '{1, 4'b1101, 1, 1, 0, 4'b1101, 1, 0, 0, 0};
      vecs[1] = '{0, 4'b1101, 1, 1, 1, 4'b1101, 1, 0, 0, 0};
      vecs[2] = '{1, 4'b1101, 0, 1, 1, 4'b1101, 0, 1, 0, 0};
      vecs[3] = '{1, 4'b1101, 0, 1, 0, 4'b1101, 0, 1, 0, 0};
      vecs[4] = '{1, 4'b1101, 1, 0, 0, 4'b1101, 0, 0, 1, 0};
      vecs[5] = '{1, 4'b1101, 1, 1, 0, 4'b1101, 1, 0, 0, 0};
      vecs[6] = '{1, 4'b0011, 0, 1, 0, 4'b1101, 1, 0, 0, 1};
      vecs[7] = '{1, 4'b0011, 0, 1, 1, 4'b0011, 1, 0, 0, 0};
      vecs[8] = '{1, 4'b0011, 1, 0, 0, 4'b0011, 1, 0, 1, 0};
      vecs[9] = '{0, 4'b0110, 0, 1, 1, 4'b0110, 1, 0, 0, 0};
      reset = 1'b1;
      sin = 1'b1;
      msb_first = 1'b1;
      q_ready = 1'b0;
      tick();
      tick();
      chk_out("reset", 4'd0, 0, 0, 0, 0);
      chk("reset_busy", 16'(busy), 16'd0);
      reset = 1'b0;
      gap(2);
      for (int i = 0; i < 10; i++) begin
         send_frame(vecs[i].o, vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].r, 0, 0);
         chk_out($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eqv, vecs[i].epe, vecs[i].efe, vecs[i].eov);
         gap(1);
      end
      // reset in the middle of a frame
      msb_first = 1'b1;
      sin = 1'b0;
      tick();
      sin = 1'b1;
      tick();
      sin = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk_out("mid_reset", 4'd0, 0, 0, 0, 0);
      chk("mid_reset_busy", 16'(busy), 16'd0);
      tick();
      reset = 1'b0;
      sin = 1'b1;
      tick();
      chk("post_reset_idle", 16'(busy), 16'd0);
      send_frame(1, 4'b0110, 0, 1, 0, 0, 0);
      chk_out("after_reset", 4'b0110, 1, 0, 0, 0);
      // back-to-back frames with q_ready held high
      send_frame(1, 4'b1010, 0, 1, 1, 1, 0);
      chk_out("b2b_a", 4'b1010, 1, 0, 0, 0);
      send_frame(0, 4'b0101, 0, 1, 1, 1, 0);
      chk_out("b2b_b", 4'b0101, 1, 0, 0, 0);
      gap(1);
      m_q = 4'b0101;
      m_qv = 1'b1;
      for (int k = 0; k < 200; k++) begin
         bit o, p, s, r, h, scr, good, pok, load, eov;
         logic [3:0] d;
         o = 1'($urandom);
         d = 4'($urandom);
         pok = ($urandom_range(0, 3) != 0);
         p = pok ? ^d : ~^d;
         s = ($urandom_range(0, 7) != 0);
         r = 1'($urandom);
         h = ($urandom_range(0, 3) == 0);
         scr = 1'($urandom);
         send_frame(o, d, p, s, r, h, scr);
         if (h && r) m_qv = 1'b0;
         good = s && pok;
         eov = good && m_qv && !r;
         load = good && (!m_qv || r);
         if (load) m_q = d;
         m_qv = load ? 1'b1 : (m_qv && r) ? 1'b0 : m_qv;
         chk_out($sformatf("rnd%0d", k), m_q, m_qv, s && !pok, !s, eov);
         gap($urandom_range(0, 2));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
